twiddle_angle_gen: RTL
======================

TWIDDLE_ANGLE_GEN -- requirements
Module: twiddle_angle_gen

Interface
REQ-001 SHALL have parameter LOG2_N, default 9, meaning log2 of the largest FFT size supported (range 2..12).
REQ-002 SHALL have parameter STAGE_W, default $clog2(LOG2_N+1), meaning the width of the stage-select input.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port i_start, input, 1 bit: one-cycle request to begin a sequence.
REQ-006 SHALL have port i_stage, input, STAGE_W bits: stage s, sampled with i_start.
REQ-007 SHALL have port i_inverse, input, 1 bit: positive angles for IFFT, sampled with i_start.
REQ-008 SHALL have port i_ready, input, 1 bit: downstream accept.
REQ-009 SHALL have port o_valid, output, 1 bit: o_data, o_index and o_last are valid.
REQ-010 SHALL have port o_data, output, 32 bits: IEEE-754 single-precision angle.
REQ-011 SHALL have port o_index, output, LOG2_N-1 bits: the index k of the current angle.
REQ-012 SHALL have port o_last, output, 1 bit: marks the final angle of the sequence.
REQ-013 SHALL have port o_busy, output, 1 bit: a sequence is in progress.
REQ-014 SHALL have port o_done, output, 1 bit: one-cycle pulse at sequence end.
REQ-015 SHALL have port o_err, output, 1 bit: one-cycle pulse when a start is rejected.

Function
REQ-016 SHALL emit angles for stage s (1..LOG2_N): count 2^(s-1); angle(k) = -k*pi/2^(s-1) for k = 0..2^(s-1)-1.
REQ-017 SHALL read one table of 2^(LOG2_N-1) entries, entry j = -j*pi/2^(LOG2_N-1), at address k << (LOG2_N-s).
- Values SHALL be bit-exact for every stage.
REQ-018 SHALL flip bit 31 of o_data when i_inverse is latched high.
- Entry 0 is 0x80000000, or 0x00000000 when inverted.
REQ-019 SHALL use FSM states IDLE -> RUN -> DRAIN -> IDLE.
- IDLE->RUN on i_start with a legal stage.
- RUN->DRAIN after the final address is issued.
- DRAIN->IDLE on the handshake of the o_last beat.
REQ-020 SHALL use a 2-stage pipeline (address counter -> registered ROM read -> output register).
- First o_valid SHALL be 2 cycles after i_start when i_ready is high.
- Throughput SHALL be one angle per cycle thereafter.
REQ-021 SHALL count a transfer as o_valid && i_ready.
- While o_valid && !i_ready: o_data, o_index and o_last SHALL hold stable, and the counter and ROM read SHALL freeze.
- No beat SHALL be lost or duplicated.
REQ-022 SHALL pulse o_done for one cycle the cycle after the o_last transfer; o_busy SHALL fall in that same cycle.
REQ-023 SHALL ignore i_start while o_busy is high; no error is flagged.
REQ-024 SHALL pulse o_err for one cycle on i_start in IDLE with stage 0 or stage > LOG2_N, and SHALL remain in IDLE.
REQ-025 SHALL, for stage 1, emit a single beat with k=0 and o_last=1.

Reset
REQ-026 SHALL, on i_rst_n low and regardless of the clock, force state IDLE, counter 0, o_valid 0, o_data 0, o_index 0, o_last 0, o_busy 0, o_done 0, o_err 0.
REQ-027 SHALL abort a sequence in flight on reset mid-sequence, with no o_done; the next legal i_start after release SHALL start a fresh sequence.

Configuration
REQ-028 SHALL compile in the i_bitrev input only when macro TWIDDLE_BITREV_EN is defined.
- i_bitrev is sampled with i_start.
- When the latched value is 1, the generator SHALL emit k in (s-1)-bit bit-reversed order.
- o_index SHALL carry the reversed k.
REQ-029 SHALL, without TWIDDLE_BITREV_EN, have no i_bitrev port and always emit natural order.

Structure
REQ-030 SHALL place constants and a table-entry function in a shared package twiddle_pkg.
- Constants: FP32_W=32, FP32_SIGN_BIT=31.
- Function: computes entry j as a shortreal converted to bits at elaboration.
REQ-031 SHALL instantiate one sub-module, twiddle_angle_rom: a parametrised 2^(LOG2_N-1) x 32 ROM with registered read and read-enable, initialised from twiddle_pkg.

Verification
REQ-032 SHALL cover: LOG2_N=9, stage 9, i_ready=1 -> 256 beats.
- k=1 gives 0xbc490fdb; k=128 gives 0xbfc90fdb; k=255 gives 0xc04846cb with o_last=1.
- o_done follows one cycle later.
REQ-033 SHALL cover: stage 2 -> k=0 gives 0x80000000, then k=1 gives 0xbfc90fdb with o_last=1; stage 1 -> a single beat 0x80000000 with o_last=1.
REQ-034 SHALL cover: stage 9 with i_inverse=1 -> k=1 gives 0x3c490fdb; k=255 gives 0x404846cb.
REQ-035 SHALL cover: random i_ready stalls on stage 8 -> the accepted stream equals 0x80000000, 0xbcc90fdb, ... with 128 beats, held stable during stalls, with no gaps or duplicates.
REQ-036 SHALL cover: stage 0 and stage 10 -> o_err pulse and no o_valid; i_start while busy is ignored; reset asserted at beat 50 -> all outputs 0, no o_done.
REQ-037 SHALL cover, with TWIDDLE_BITREV_EN: stage 3 with i_bitrev=1 -> k sequence 0,2,1,3 giving 0x80000000, 0xbfc90fdb, 0xbf490fdb, 0xc016cbe4.

Source files
------------

// File: rtl/twiddle_pkg.sv
// Shared constants and the twiddle-angle table-entry function.
// Entries are computed at elaboration and rounded to IEEE-754 single precision.
// No runtime logic lives here.
package twiddle_pkg;

  localparam int  FP32_W        = 32;
  localparam int  FP32_SIGN_BIT = 31;
  localparam real PI            = 3.14159265358979323846;

  // Entry j = -j*pi/2^(log2_n-1) as a single-precision bit pattern. The product
  // is formed in double precision and then rounded to nearest-even into the
  // 23-bit mantissa. The sign is forced to 1 so that entry 0 is -0.0
  // (0x80000000). Every nonzero magnitude lies in [pi/2048, pi), which is well
  // inside the normal range, so subnormals and overflow cannot occur.
  function automatic logic [FP32_W-1:0] twiddle_entry(input int j, input int log2_n);
    real        m;
    real        f;
    real        rem;
    int         e;
    int         fi;
    logic [7:0]  exp_f;
    logic [22:0] man_f;
    if (j == 0) return {1'b1, {(FP32_W-1){1'b0}}};
    m = (real'(j) * PI) / real'(1 << (log2_n - 1));
    e = 0;
    for (int i = 0; i < 16; i++) begin
      if (m >= 2.0) begin
        m = m / 2.0;
        e = e + 1;
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (m < 1.0) begin
        m = m * 2.0;
        e = e - 1;
      end
    end
    f   = (m - 1.0) * 8388608.0;
    fi  = $rtoi(f);
    rem = f - real'(fi);
    if (rem > 0.5 || (rem == 0.5 && fi[0])) fi = fi + 1;
    if (fi == 8388608) begin
      fi = 0;
      e  = e + 1;
    end
    exp_f = 8'(e + 127);
    man_f = 23'(fi);
    return {1'b1, exp_f, man_f};
  endfunction

endpackage

// File: rtl/twiddle_angle_rom.sv
// Twiddle angle ROM: 2^(LOG2_N-1) x 32 entries, filled from twiddle_pkg.
// Latency: 1 cycle (registered read).
// Backpressure: o_rd_data holds its value while i_rd_en is low.
module twiddle_angle_rom
  import twiddle_pkg::*;
#(
  parameter int LOG2_N = 9
) (
  input  logic                i_clk,
  input  logic                i_rd_en,
  input  logic [LOG2_N-2:0]   i_addr,
  output logic [FP32_W-1:0]   o_rd_data
);

  localparam int DEPTH = 1 << (LOG2_N - 1);

  logic [FP32_W-1:0] table_mem [DEPTH];

  // Constant table contents: every entry folds to a literal at elaboration.
  for (genvar j = 0; j < DEPTH; j++) begin : g_entry
    assign table_mem[j] = twiddle_entry(j, LOG2_N);
  end

  // Registered read. Holding i_rd_en low freezes the output.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) o_rd_data <= table_mem[i_addr];
  end

endmodule

// File: rtl/twiddle_angle_gen.sv
// Twiddle angle generator: streams -k*pi/2^(s-1) for k = 0..2^(s-1)-1 (optional i_bitrev via TWIDDLE_BITREV_EN).
// Latency: first o_valid 2 cycles after an accepted i_start, then one angle per cycle.
// Backpressure: o_valid && !i_ready freezes counter, ROM read and output register (all beats are held).
module twiddle_angle_gen
  import twiddle_pkg::*;
#(
  parameter int LOG2_N  = 9,
  parameter int STAGE_W = $clog2(LOG2_N + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [STAGE_W-1:0]  i_stage,
  input  logic                i_inverse,
`ifdef TWIDDLE_BITREV_EN
  input  logic                i_bitrev,
`endif
  input  logic                i_ready,
  output logic                o_valid,
  output logic [FP32_W-1:0]   o_data,
  output logic [LOG2_N-2:0]   o_index,
  output logic                o_last,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int IDX_W = LOG2_N - 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]         state;
  logic [IDX_W-1:0]   cnt;        // next natural-order k to issue
  logic [IDX_W-1:0]   last_k;     // 2^(s-1)-1 for the latched stage
  logic [STAGE_W-1:0] shamt_q;    // LOG2_N - s: k-to-address shift
  logic               inverse_q;

  logic               p1_vld;
  logic [IDX_W-1:0]   p1_idx;
  logic               p1_last;
  logic [FP32_W-1:0]  rom_q;

  logic               stage_ok;
  logic               start_ok;
  logic               start_bad;
  logic               advance;
  logic               issue_run;
  logic               rd_en;
  logic               issue_last;
  logic               last_xfer;
  logic [IDX_W-1:0]   k_nat;
  logic [IDX_W-1:0]   k_emit;
  logic [IDX_W-1:0]   rd_addr;

`ifdef TWIDDLE_BITREV_EN
  logic               bitrev_q;

  function automatic logic [IDX_W-1:0] rev_bits(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    for (int i = 0; i < IDX_W; i++) r[i] = v[IDX_W-1-i];
    return r;
  endfunction
`endif

  // Start qualification, stall control and the address of the angle issued this cycle.
  always_comb begin
    stage_ok   = (i_stage != '0) && (int'(i_stage) <= LOG2_N);
    start_ok   = (state == ST_IDLE) && i_start && stage_ok;
    start_bad  = (state == ST_IDLE) && i_start && !stage_ok;
    advance    = !o_valid || i_ready;
    issue_run  = (state == ST_RUN) && advance;
    rd_en      = start_ok || issue_run;
    k_nat      = start_ok ? '0 : cnt;
    issue_last = start_ok ? (int'(i_stage) == 1) : (cnt == last_k);
    last_xfer  = o_valid && i_ready && o_last;
`ifdef TWIDDLE_BITREV_EN
    // Full-width reversal then shift down, which reverses within the s-1 low bits.
    // The start beat is k=0 and its reversal is also 0.
    k_emit     = bitrev_q ? (rev_bits(k_nat) >> shamt_q) : k_nat;
`else
    k_emit     = k_nat;
`endif
    rd_addr    = k_emit << shamt_q;
  end

  // Sequence FSM plus the per-sequence parameters latched on an accepted start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last_k    <= '0;
      shamt_q   <= '0;
      inverse_q <= 1'b0;
`ifdef TWIDDLE_BITREV_EN
      bitrev_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state     <= (int'(i_stage) == 1) ? ST_DRAIN : ST_RUN;
            cnt       <= IDX_W'(1);
            last_k    <= IDX_W'((1 << (int'(i_stage) - 1)) - 1);
            shamt_q   <= STAGE_W'(LOG2_N - int'(i_stage));
            inverse_q <= i_inverse;
`ifdef TWIDDLE_BITREV_EN
            bitrev_q  <= i_bitrev;
`endif
          end
        end
        ST_RUN: begin
          if (issue_run) begin
            cnt <= cnt + IDX_W'(1);
            if (cnt == last_k) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_xfer) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Two-register pipeline (ROM read stage, output stage) that advances as one unit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p1_vld  <= 1'b0;
      p1_idx  <= '0;
      p1_last <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_index <= '0;
      o_last  <= 1'b0;
    end else if (advance) begin
      p1_vld  <= rd_en;
      p1_idx  <= k_emit;
      p1_last <= rd_en && issue_last;
      o_valid <= p1_vld;
      o_data  <= p1_vld ? (rom_q ^ {inverse_q, {(FP32_W-1){1'b0}}}) : '0;
      o_index <= p1_vld ? p1_idx : '0;
      o_last  <= p1_vld && p1_last;
    end
  end

  // Single-cycle status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      o_done <= (state == ST_DRAIN) && last_xfer;
      o_err  <= start_bad;
    end
  end

  assign o_busy = (state != ST_IDLE);

  twiddle_angle_rom #(
    .LOG2_N (LOG2_N)
  ) u_rom (
    .i_clk     (i_clk),
    .i_rd_en   (rd_en),
    .i_addr    (rd_addr),
    .o_rd_data (rom_q)
  );

endmodule
